// File: rtl/writeback_stage_if.sv
// Late long-latency result port into the writeback stage.
// The source drives valid/dest/data and holds them until ready.
interface writeback_stage_if;
    logic        md_valid;
    logic [4:0]  md_dest;
    logic [31:0] md_data;
    logic        md_ready;

    modport master (
        output md_valid,
        output md_dest,
        output md_data,
        input  md_ready
    );

    modport slave (
        input  md_valid,
        input  md_dest,
        input  md_data,
        output md_ready
    );
endinterface

// File: rtl/writeback_stage.sv
// MEM/WB register, load extension and register-file write-port arbiter.
// The pipeline owns the port; late results use it directly or via a 1-entry buffer.
module writeback_stage (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               mem_reg_write,
    input  logic [4:0]         mem_dest,
    input  logic [1:0]         mem_wb_sel,
    input  logic [31:0]        mem_alu_result,
    input  logic [31:0]        mem_read_data,
    input  logic [31:0]        mem_pc_plus8,
    input  logic [1:0]         mem_load_size,
    input  logic               mem_load_unsigned,
    writeback_stage_if.slave   md,
    output logic               reg_write,
    output logic [4:0]         WriteRegister,
    output logic [31:0]        WriteData
);

    logic        r_valid;
    logic        r_reg_write;
    logic [4:0]  r_dest;
    logic [1:0]  r_wb_sel;
    logic [31:0] r_alu;
    logic [31:0] r_rdata;
    logic [31:0] r_pc8;
    logic [1:0]  r_lsize;
    logic        r_uns;
    logic        r_done;

    logic        r_pend_valid;
    logic [4:0]  r_pend_dest;
    logic [31:0] r_pend_data;

    logic        w_pw;
    logic        w_md_live;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_result;

    assign w_pw = r_valid & r_reg_write & ~r_done & (r_dest != 5'd0);
    assign md.md_ready = rst & ~r_pend_valid;
    assign w_md_live = md.md_valid & md.md_ready & (md.md_dest != 5'd0);

    // MEM/WB register: reset, bubble, hold (marking issued writes), capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_dest      <= 5'd0;
            r_wb_sel    <= 2'd0;
            r_alu       <= 32'd0;
            r_rdata     <= 32'd0;
            r_pc8       <= 32'd0;
            r_lsize     <= 2'd0;
            r_uns       <= 1'b0;
            r_done      <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else if (stall) begin
            if (w_pw)
                r_done <= 1'b1;
        end else begin
            r_valid     <= 1'b1;
            r_reg_write <= mem_reg_write;
            r_dest      <= mem_dest;
            r_wb_sel    <= mem_wb_sel;
            r_alu       <= mem_alu_result;
            r_rdata     <= mem_read_data;
            r_pc8       <= mem_pc_plus8;
            r_lsize     <= mem_load_size;
            r_uns       <= mem_load_unsigned;
            r_done      <= 1'b0;
        end
    end

    // Pending buffer: park a late result that lost the port, drain when free
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pend_valid <= 1'b0;
            r_pend_dest  <= 5'd0;
            r_pend_data  <= 32'd0;
        end else if (w_md_live && w_pw) begin
            r_pend_valid <= 1'b1;
            r_pend_dest  <= md.md_dest;
            r_pend_data  <= md.md_data;
        end else if (r_pend_valid && !w_pw) begin
            r_pend_valid <= 1'b0;
        end
    end

    // Little-endian lane pick and sign/zero extension of loads
    always_comb begin
        w_byte = r_rdata[7:0];
        case (r_alu[1:0])
            2'd1:    w_byte = r_rdata[15:8];
            2'd2:    w_byte = r_rdata[23:16];
            2'd3:    w_byte = r_rdata[31:24];
            default: w_byte = r_rdata[7:0];
        endcase
        w_half = r_alu[1] ? r_rdata[31:16] : r_rdata[15:0];
        case (r_lsize)
            2'b01:   w_load = {{16{w_half[15] & ~r_uns}}, w_half};
            2'b10:   w_load = {{24{w_byte[7] & ~r_uns}}, w_byte};
            default: w_load = r_rdata;
        endcase
    end

    // Writeback source select
    always_comb begin
        case (r_wb_sel)
            2'b01:   w_result = w_load;
            2'b10:   w_result = r_pc8;
            default: w_result = r_alu;
        endcase
    end

    // Write port arbitration: pipeline, then pending, then direct late result
    always_comb begin
        reg_write     = 1'b0;
        WriteRegister = 5'd0;
        WriteData     = 32'd0;
        if (w_pw) begin
            reg_write     = 1'b1;
            WriteRegister = r_dest;
            WriteData     = w_result;
        end else if (r_pend_valid) begin
            reg_write     = 1'b1;
            WriteRegister = r_pend_dest;
            WriteData     = r_pend_data;
        end else if (w_md_live) begin
            reg_write     = 1'b1;
            WriteRegister = md.md_dest;
            WriteData     = md.md_data;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: vector table plus
// hand-written multi-cycle sequences.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        mem_reg_write;
    logic [4:0]  mem_dest;
    logic [1:0]  mem_wb_sel;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_read_data;
    logic [31:0] mem_pc_plus8;
    logic [1:0]  mem_load_size;
    logic        mem_load_unsigned;
    logic        reg_write;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;

    int total = 0;
    int bad = 0;

    writeback_stage_if mdif ();

    writeback_stage dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .flush             (flush),
        .mem_reg_write     (mem_reg_write),
        .mem_dest          (mem_dest),
        .mem_wb_sel        (mem_wb_sel),
        .mem_alu_result    (mem_alu_result),
        .mem_read_data     (mem_read_data),
        .mem_pc_plus8      (mem_pc_plus8),
        .mem_load_size     (mem_load_size),
        .mem_load_unsigned (mem_load_unsigned),
        .md                (mdif.slave),
        .reg_write         (reg_write),
        .WriteRegister     (WriteRegister),
        .WriteData         (WriteData)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [4:0]  dest;
        logic [1:0]  sel;
        logic [31:0] alu;
        logic [31:0] rd;
        logic [31:0] pc8;
        logic [1:0]  ls;
        logic        uns;
        logic        exp_we;
        logic [4:0]  exp_dest;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_port(input string nm, input logic we,
                            input logic [4:0] d, input logic [31:0] dat);
        chk({nm, ".we"}, {31'd0, reg_write}, {31'd0, we});
        chk({nm, ".dest"}, {27'd0, WriteRegister}, {27'd0, d});
        chk({nm, ".data"}, WriteData, dat);
    endtask

    task automatic drive_mem(input logic rw, input logic [4:0] d,
                             input logic [1:0] sel, input logic [31:0] alu);
        mem_reg_write  = rw;
        mem_dest       = d;
        mem_wb_sel     = sel;
        mem_alu_result = alu;
        mem_load_size  = 2'b00;
    endtask

    initial begin
        int wcount;
        vt[0]  = '{1'b1, 5'd8, 2'b00, 32'h1234, 32'h0, 32'h0, 2'b00, 1'b0,
                   1'b1, 5'd8, 32'h00001234};
        vt[1]  = '{1'b1, 5'd8, 2'b10, 32'h1234, 32'h0, 32'h400010, 2'b00, 1'b0,
                   1'b1, 5'd8, 32'h00400010};
        vt[2]  = '{1'b1, 5'd2, 2'b01, 32'h2, 32'h80FF7F01, 32'h0, 2'b10, 1'b0,
                   1'b1, 5'd2, 32'hFFFFFFFF};
        vt[3]  = '{1'b1, 5'd2, 2'b01, 32'h3, 32'h80FF7F01, 32'h0, 2'b10, 1'b1,
                   1'b1, 5'd2, 32'h00000080};
        vt[4]  = '{1'b1, 5'd2, 2'b01, 32'h1, 32'h80FF7F01, 32'h0, 2'b01, 1'b0,
                   1'b1, 5'd2, 32'h00007F01};
        vt[5]  = '{1'b1, 5'd2, 2'b01, 32'h2, 32'h80FF7F01, 32'h0, 2'b01, 1'b1,
                   1'b1, 5'd2, 32'h000080FF};
        vt[6]  = '{1'b1, 5'd2, 2'b01, 32'h1003, 32'h80FF7F01, 32'h0, 2'b00, 1'b0,
                   1'b1, 5'd2, 32'h80FF7F01};
        vt[7]  = '{1'b1, 5'd2, 2'b01, 32'h1, 32'h80FF7F01, 32'h0, 2'b10, 1'b0,
                   1'b1, 5'd2, 32'h0000007F};
        vt[8]  = '{1'b1, 5'd0, 2'b00, 32'h77, 32'h0, 32'h0, 2'b00, 1'b0,
                   1'b0, 5'd0, 32'h0};
        vt[9]  = '{1'b0, 5'd4, 2'b00, 32'h99, 32'h0, 32'h0, 2'b00, 1'b0,
                   1'b0, 5'd0, 32'h0};
        vt[10] = '{1'b1, 5'd1, 2'b11, 32'hDEADBEEF, 32'h0, 32'h0, 2'b00, 1'b0,
                   1'b1, 5'd1, 32'hDEADBEEF};
        vt[11] = '{1'b1, 5'd3, 2'b01, 32'h2, 32'h80FF7F01, 32'h0, 2'b11, 1'b1,
                   1'b1, 5'd3, 32'h80FF7F01};

        // Reset with every input active
        rst = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drive_mem(1'b1, 5'd7, 2'b00, 32'h1111);
        mem_read_data = 32'h0;
        mem_pc_plus8 = 32'h0;
        mem_load_unsigned = 1'b0;
        mdif.md_valid = 1'b1;
        mdif.md_dest = 5'd4;
        mdif.md_data = 32'h4444;
        step();
        chk_port("rst0", 1'b0, 5'd0, 32'h0);
        chk("rst0.ready", {31'd0, mdif.md_ready}, 32'd0);
        step();
        chk_port("rst1", 1'b0, 5'd0, 32'h0);
        chk("rst1.ready", {31'd0, mdif.md_ready}, 32'd0);
        mdif.md_valid = 1'b0;
        mem_reg_write = 1'b0;
        rst = 1'b1;
        step();
        chk_port("post_rst", 1'b0, 5'd0, 32'h0);
        chk("post_rst.ready", {31'd0, mdif.md_ready}, 32'd1);

        // Table vectors
        for (int i = 0; i < 12; i++) begin
            mem_reg_write     = vt[i].rw;
            mem_dest          = vt[i].dest;
            mem_wb_sel        = vt[i].sel;
            mem_alu_result    = vt[i].alu;
            mem_read_data     = vt[i].rd;
            mem_pc_plus8      = vt[i].pc8;
            mem_load_size     = vt[i].ls;
            mem_load_unsigned = vt[i].uns;
            step();
            chk_port($sformatf("vec%0d", i), vt[i].exp_we,
                     vt[i].exp_dest, vt[i].exp_data);
        end

        // md to $0 is swallowed; direct md write is combinational
        drive_mem(1'b0, 5'd0, 2'b00, 32'h0);
        step();
        mdif.md_valid = 1'b1;
        mdif.md_dest = 5'd0;
        mdif.md_data = 32'h1234;
        #1;
        chk("md0.ready", {31'd0, mdif.md_ready}, 32'd1);
        chk_port("md0", 1'b0, 5'd0, 32'h0);
        step();
        mdif.md_valid = 1'b0;
        #1;
        chk("md0.ready_after", {31'd0, mdif.md_ready}, 32'd1);
        chk_port("md0.after", 1'b0, 5'd0, 32'h0);
        mdif.md_valid = 1'b1;
        mdif.md_dest = 5'd12;
        mdif.md_data = 32'h55;
        #1;
        chk_port("md_direct", 1'b1, 5'd12, 32'h55);
        step();
        mdif.md_valid = 1'b0;
        #1;
        chk_port("md_direct.once", 1'b0, 5'd0, 32'h0);

        // Collision: pipeline to 5 and md to 9 together
        drive_mem(1'b1, 5'd5, 2'b00, 32'h5555);
        step();
        drive_mem(1'b0, 5'd0, 2'b00, 32'h0);
        mdif.md_valid = 1'b1;
        mdif.md_dest = 5'd9;
        mdif.md_data = 32'hCAFE;
        #1;
        chk("col.ready0", {31'd0, mdif.md_ready}, 32'd1);
        chk_port("col.pw", 1'b1, 5'd5, 32'h5555);
        step();
        mdif.md_valid = 1'b0;
        #1;
        chk("col.ready1", {31'd0, mdif.md_ready}, 32'd0);
        chk_port("col.pend", 1'b1, 5'd9, 32'hCAFE);
        step();
        chk_port("col.idle", 1'b0, 5'd0, 32'h0);
        chk("col.ready2", {31'd0, mdif.md_ready}, 32'd1);

        // Stall on a write to 3 with a late result arriving meanwhile
        drive_mem(1'b1, 5'd3, 2'b00, 32'h33);
        step();
        stall = 1'b1;
        mdif.md_valid = 1'b1;
        mdif.md_dest = 5'd10;
        mdif.md_data = 32'hAA;
        #1;
        chk_port("stall.pw", 1'b1, 5'd3, 32'h33);
        wcount = 1;
        step();
        mdif.md_valid = 1'b0;
        #1;
        chk_port("stall.pend", 1'b1, 5'd10, 32'hAA);
        for (int c = 0; c < 3; c++) begin
            step();
            if (reg_write && WriteRegister == 5'd3)
                wcount++;
        end
        chk("stall.writes_to_3", wcount, 1);
        chk_port("stall.end", 1'b0, 5'd0, 32'h0);

        // Flush overrides stall
        drive_mem(1'b1, 5'd4, 2'b00, 32'h44);
        flush = 1'b1;
        step();
        chk_port("flush_stall", 1'b0, 5'd0, 32'h0);
        flush = 1'b0;
        stall = 1'b0;
        drive_mem(1'b0, 5'd0, 2'b00, 32'h0);
        step();

        // Reset while pending holds a late result
        drive_mem(1'b1, 5'd6, 2'b00, 32'h66);
        step();
        drive_mem(1'b1, 5'd7, 2'b00, 32'h77);
        mdif.md_valid = 1'b1;
        mdif.md_dest = 5'd11;
        mdif.md_data = 32'hBB;
        step();
        mdif.md_valid = 1'b0;
        drive_mem(1'b0, 5'd0, 2'b00, 32'h0);
        #1;
        chk_port("rstp.pw7", 1'b1, 5'd7, 32'h77);
        chk("rstp.ready", {31'd0, mdif.md_ready}, 32'd0);
        rst = 1'b0;
        step();
        chk_port("rstp.in_rst", 1'b0, 5'd0, 32'h0);
        rst = 1'b1;
        wcount = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (reg_write)
                wcount++;
        end
        chk("rstp.no_write", wcount, 0);
        chk("rstp.ready_after", {31'd0, mdif.md_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
